// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential NxN signed matrix / Hadamard product using a single multiplier
module mat_mult_seq #(
  parameter int N = 2,
  parameter int W = 27
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic                         mat_mode,
  input  logic [N-1:0][N-1:0][W-1:0]   dataa,
  input  logic [N-1:0][N-1:0][W-1:0]   datab,
  output logic                         busy,
  output logic                         done,
  output logic [N-1:0][N-1:0][W-1:0]   result
);
  localparam int CW = $clog2(N);
  localparam int AW = 2 * W + CW;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                       r_state, w_next;
  logic [N-1:0][N-1:0][W-1:0]   r_a, r_b;
  logic                         r_mode;
  logic [CW-1:0]                r_i, r_j, r_k;
  logic signed [AW-1:0]         r_acc;
  logic signed [W-1:0]          w_ma, w_mb;
  logic signed [2*W-1:0]        w_prod;
  logic signed [AW-1:0]         w_sum;
  logic                         w_last_k, w_last_j, w_last;
  assign w_ma     = r_mode ? r_a[r_i][r_j] : r_a[r_i][r_k];
  assign w_mb     = r_mode ? r_b[r_i][r_j] : r_b[r_k][r_j];
  assign w_prod   = w_ma * w_mb;
  assign w_sum    = r_acc + {{CW{w_prod[2*W-1]}}, w_prod};
  assign w_last_k = r_mode | (r_k == CW'(N - 1));
  assign w_last_j = w_last_k & (r_j == CW'(N - 1));
  assign w_last   = w_last_j & (r_i == CW'(N - 1));
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
  // next state: advance only on enabled edges, DONE lasts one enabled cycle
  always_comb begin
    w_next = r_state;
    if (en)
      case (r_state)
        IDLE:    w_next = start ? CALC : IDLE;
        CALC:    w_next = w_last ? DONE : CALC;
        default: w_next = IDLE;
      endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // operand latch, i/j/k loop counters, one multiply-accumulate per enabled CALC edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      result <= '0;
    end else if (en) begin
      if (r_state == IDLE && start) begin
        r_a    <= dataa;
        r_b    <= datab;
        r_mode <= mat_mode;
        r_i    <= '0;
        r_j    <= '0;
        r_k    <= '0;
        r_acc  <= '0;
      end else if (r_state == CALC) begin
        if (w_last_k) begin
          result[r_i][r_j] <= w_sum[W-1:0];
          r_acc <= '0;
          r_k   <= '0;
          r_j   <= w_last_j ? '0 : r_j + CW'(1);
          if (w_last_j) r_i <= w_last ? '0 : r_i + CW'(1);
        end else begin
          r_k   <= r_k + CW'(1);
          r_acc <= w_sum;
        end
      end
    end
  end
endmodule

// File: doc/mat_mult_seq.md
MAT_MULT_SEQ -- requirements
Module: mat_mult_seq

Interface
REQ-001 The block SHALL have parameter N, default 2, matrix dimension (N >= 2).
REQ-002 The block SHALL have parameter W, default 27, element width in bits (signed two's complement).
REQ-003 The block SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  global enable; when low, all internal state SHALL hold.
REQ-006 The block SHALL have port start  input  1  operation request, sampled only in IDLE with en=1.
REQ-007 The block SHALL have port mat_mode  input  1  0 = matrix product A*B, 1 = element-wise (Hadamard) product; sampled with start.
REQ-008 The block SHALL have port dataa  input  [N-1:0][N-1:0][W-1:0]  operand A, indexed [row][col], sampled with start.
REQ-009 The block SHALL have port datab  input  [N-1:0][N-1:0][W-1:0]  operand B, indexed [row][col], sampled with start.
REQ-010 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 The block SHALL have port done  output  1  high exactly while the state is DONE.
REQ-012 The block SHALL have port result  output  [N-1:0][N-1:0][W-1:0]  registered result matrix, indexed [row][col].

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE->CALC SHALL occur on an edge with en=1 and start=1; on that edge dataa, datab and mat_mode SHALL be latched and the counters i, j, k and the accumulator SHALL be cleared.
REQ-015 CALC SHALL perform one signed W x W multiply and one accumulate per enabled edge, using a single multiplier.
REQ-016 In mode 0, CALC SHALL iterate i (outer), j, k (inner) over 0..N-1, accumulating A[i][k]*B[k][j].
REQ-017 In mode 0, when k=N-1, result[i][j] SHALL be written on that edge and the accumulator cleared.
REQ-018 In mode 1, CALC SHALL iterate i (outer), j (inner) over 0..N-1 with no k loop, writing result[i][j] = A[i][j]*B[i][j].
REQ-019 The accumulator SHALL be at least 2W+clog2(N) bits wide; each written element SHALL be its low W bits, with wrap-around and no saturation.
REQ-020 CALC SHALL last K enabled edges (K = N^3 in mode 0, N^2 in mode 1); the K-th edge SHALL write the last element and enter DONE.
REQ-021 done SHALL therefore be high in the cycle following the K-th enabled edge after the edge that accepted start (8 cycles for N=2 mode 0; 4 cycles for N=2 mode 1).
REQ-022 DONE->IDLE SHALL occur on the next enabled edge, so done is a single enabled cycle; with en low, DONE and done SHALL hold.
REQ-023 result elements SHALL change only when written during CALC; between operations result SHALL hold its last value.
REQ-024 start SHALL be ignored in CALC and DONE; no queuing SHALL occur.
REQ-025 Operand inputs SHALL be don't-care after the start edge; changes to them SHALL NOT affect the operation in flight.
REQ-026 With en=0, state, counters, accumulator and result SHALL hold, and start SHALL be ignored.

Reset
REQ-027 rst=1 on any edge SHALL force state IDLE, busy=0, done=0, clear counters, accumulator and latched operands, and set all result elements to 0.
REQ-028 rst SHALL take priority over en and start, including when asserted mid-CALC or in DONE.

Verification
REQ-029 The bench SHALL cover mode 0 with N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], en=1 -> result=[[19,22],[43,50]], done pulse exactly 8 cycles after start, busy high 9 cycles.
REQ-030 The bench SHALL cover mode 1 with the same operands -> result=[[5,12],[21,32]], done 4 cycles after start.
REQ-031 The bench SHALL cover signed values and wrap: mode 1, A[0][0]=2^26-1, B[0][0]=2 -> result[0][0]=-2 (27-bit); A=[[-3,0],[0,-3]], B=[[1,2],[3,4]], mode 0 -> [[-3,-6],[-9,-12]].
REQ-032 The bench SHALL cover a stall: mode 0 run with en held low for 3 cycles mid-CALC -> correct result, done at 11 cycles, state frozen during the stall.
REQ-033 The bench SHALL cover reset mid-operation: rst asserted at cycle 4 of a mode 0 run -> next cycle busy=0, done=0, result all 0; a following start completes normally.
REQ-034 The bench SHALL cover start while busy: a second start with different operands during CALC -> ignored; first result correct; exactly one done pulse.
